// File: rtl/dda_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dda_pkg
// Purpose  : Shared constants, FSM encoding and checksum helper for the
//            DDA state streaming path.
// Revision : 1.0 - initial release
// ============================================================================
package dda_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES       = 6;
    localparam int         BITS_PER_BYTE     = 10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic [7:0] frame_chk(input logic [15:0] x, input logic [15:0] y);
        return x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_8n1
// Purpose  : 8N1 serial transmitter, DIV clocks per bit, idle-high line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_8n1
    import dda_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int             BW        = $clog2(DIV);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0]  BAUD_DONE = BW'(DIV - 2);
    localparam logic [3:0]     BIT_STOP  = 4'(BITS_PER_BYTE - 1);

    logic          r_active;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_data   <= '0;
            r_tx     <= 1'b1;
        end else if (!r_active) begin
            if (start) begin
                r_active <= 1'b1;
                r_baud   <= '0;
                r_bit    <= '0;
                r_data   <= data;
                r_tx     <= 1'b0;
            end
        end else if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == BIT_STOP) begin
                r_active <= 1'b0;
                r_bit    <= '0;
            end else begin
                r_bit <= r_bit + 4'd1;
                // r_bit==8 is the last data bit, so the stop bit follows
                r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_data[r_bit[2:0]];
            end
        end else begin
            r_baud <= r_baud + BW'(1);
        end
    end

    // done leads the end of the stop bit by two clocks so the caller's
    // NEXT/LOAD cycles overlap the stop-bit tail, leaving a one-clock gap.
    assign done = r_active && (r_bit == BIT_STOP) && (r_baud == BAUD_DONE);
    assign busy = r_active;
    assign tx   = r_tx;

endmodule
`default_nettype wire

// File: rtl/dda_state_tx.sv
`default_nettype none
// ============================================================================
// Module   : dda_state_tx
// Purpose  : Snapshots posit16 DDA state x,y on a strobe and streams it as a
//            framed, XOR-checksummed 8N1 byte sequence on one serial pin.
// Revision : 1.0 - initial release
// ============================================================================
module dda_state_tx
    import dda_pkg::*;
#(
    parameter int         N         = 16,
    parameter int         CLK_FREQ  = 12000000,
    parameter int         BAUD_RATE = 9600,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sample,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         tx,
    output logic         busy,
    output logic         frame_done,
    output logic         overrun
);

    localparam int         DIV      = CLK_FREQ / BAUD_RATE;
    localparam logic [2:0] IDX_LAST = 3'(FRAME_BYTES - 1);

    logic [2:0]   r_state;
    logic [2:0]   r_idx;
    logic [N-1:0] r_snap_x;
    logic [N-1:0] r_snap_y;
    logic         r_busy;
    logic         r_frame_done;
    logic         r_overrun;

    logic         w_accept;
    logic [7:0]   w_byte;
    logic [7:0]   w_chk;
    logic         w_uart_start;
    logic         w_uart_done;
    logic         w_uart_busy;

    assign w_accept     = sample && en && !r_busy;
    assign w_chk        = frame_chk(r_snap_x, r_snap_y);
    assign w_uart_start = (r_state == ST_LOAD) && !w_uart_busy;

    always_comb begin
        w_byte = SYNC_BYTE;
        case (r_idx)
            3'd1:    w_byte = r_snap_x[15:8];
            3'd2:    w_byte = r_snap_x[7:0];
            3'd3:    w_byte = r_snap_y[15:8];
            3'd4:    w_byte = r_snap_y[7:0];
            3'd5:    w_byte = w_chk;
            default: w_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_snap_x <= '0;
            r_snap_y <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_snap_x <= x;
                        r_snap_y <= y;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_uart_done) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered pulses: frame_done lands exactly as busy drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_DONE);
            r_overrun    <= sample && en && r_busy;
        end
    end

    uart_tx_8n1 #(
        .DIV (DIV)
    ) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_uart_start),
        .data  (w_byte),
        .tx    (tx),
        .done  (w_uart_done),
        .busy  (w_uart_busy)
    );

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dda_state_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dda_state_tx
// Purpose  : Self-checking bench for dda_state_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dda_state_tx;

    localparam int DIV        = 4;
    localparam int BYTE_CLKS  = 10 * DIV + 1;
    localparam int FRAME_CLKS = 6 * BYTE_CLKS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sample = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes [6];
    logic       exp_wave  [FRAME_CLKS];

    always #5 clk = ~clk;

    dda_state_tx #(
        .N         (16),
        .CLK_FREQ  (16),
        .BAUD_RATE (4),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sample     (sample),
        .x          (x),
        .y          (y),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // Reference: byte list, then the ideal line level for every clock of the frame
    task automatic build_model(input logic [15:0] fx, input logic [15:0] fy);
        int p;
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = fx[15:8];
        exp_bytes[2] = fx[7:0];
        exp_bytes[3] = fy[15:8];
        exp_bytes[4] = fy[7:0];
        exp_bytes[5] = exp_bytes[1] ^ exp_bytes[2] ^ exp_bytes[3] ^ exp_bytes[4];
        p = 0;
        for (int j = 0; j < 6; j++) begin
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < DIV; c++) begin
                    if (b == 0)      exp_wave[p] = 1'b0;
                    else if (b == 9) exp_wave[p] = 1'b1;
                    else             exp_wave[p] = exp_bytes[j][b-1];
                    p++;
                end
            end
            exp_wave[p] = 1'b1;
            p++;
        end
    endtask

    // Launches one frame and follows it to frame_done. inj/drop/chg are cycle
    // offsets after the accept edge (-1 = unused) for a second sample, en drop
    // and an input change.
    task automatic run_frame(input logic [15:0] fx, input logic [15:0] fy,
                             input int inj, input int drop, input int chg, input string tag);
        logic       obs [FRAME_CLKS];
        logic [7:0] got;
        int         bad_busy, bad_fd, bad_ov, bad_wave, first_bad;
        bad_busy = 0; bad_fd = 0; bad_ov = 0; bad_wave = 0; first_bad = -1;
        build_model(fx, fy);
        x = fx; y = fy; en = 1'b1; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        for (int k = 1; k <= FRAME_CLKS + 1; k++) begin
            if (k >= 2) obs[k-2] = tx;
            if (busy !== 1'b1) bad_busy++;
            if (frame_done !== 1'b0) bad_fd++;
            if (overrun !== ((k == inj + 1) ? 1'b1 : 1'b0)) bad_ov++;
            sample = (k == inj);
            if (k == drop) en = 1'b0;
            if (k == chg) begin
                x = 16'h7240;
                y = ~fy;
            end
            @(negedge clk);
        end
        sample = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end: frame_done=%b busy=%b required frame_done=1 busy=0", tag, frame_done, busy);
        end
        checks++;
        if (overrun !== ((inj == FRAME_CLKS + 1) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL %s overrun at end: got %b required %b", tag, overrun, (inj == FRAME_CLKS + 1));
        end
        checks++;
        if (bad_busy != 0 || bad_fd != 0 || bad_ov != 0) begin
            errors++;
            $display("FAIL %s in-frame flags: busy errs %0d frame_done errs %0d overrun errs %0d required 0 each",
                     tag, bad_busy, bad_fd, bad_ov);
        end
        for (int i = 0; i < FRAME_CLKS; i++) begin
            if (obs[i] !== exp_wave[i]) begin
                if (first_bad < 0) first_bad = i;
                bad_wave++;
            end
        end
        checks++;
        if (bad_wave != 0) begin
            errors++;
            $display("FAIL %s tx waveform: %0d bad clocks, first at %0d got %b required %b",
                     tag, bad_wave, first_bad, obs[first_bad], exp_wave[first_bad]);
        end
        for (int j = 0; j < 6; j++) begin
            for (int b = 0; b < 8; b++) got[b] = obs[j*BYTE_CLKS + (b+1)*DIV + DIV/2];
            checks++;
            if (got !== exp_bytes[j]) begin
                errors++;
                $display("FAIL %s byte %0d: got %02h required %02h", tag, j, got, exp_bytes[j]);
            end
        end
    endtask

    task automatic check_quiet(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s quiet: %0d active clocks, required 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset values: tx=%b busy=%b fd=%b ov=%b required 1 0 0 0", tx, busy, frame_done, overrun);
        end
        rst_n = 1'b1;
        check_quiet(5, "post_reset");
    endtask

    task automatic test_single_frame();
        run_frame(16'hC000, 16'h14CD, -1, -1, -1, "single");
        check_quiet(10, "single");
    endtask

    task automatic test_snapshot_hold();
        run_frame(16'hC000, 16'h14CD, -1, -1, 1, "snapshot");
        check_quiet(5, "snapshot");
    endtask

    task automatic test_overrun();
        run_frame(16'($urandom), 16'($urandom), 20, -1, -1, "overrun20");
        check_quiet(60, "overrun20");
        run_frame(16'($urandom), 16'($urandom), FRAME_CLKS + 1, -1, -1, "overrun_done");
        check_quiet(60, "overrun_done");
    endtask

    task automatic test_enable();
        en = 1'b0;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        check_quiet(30, "en_low");
        run_frame(16'($urandom), 16'($urandom), -1, 100, -1, "en_drop");
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        check_quiet(30, "en_drop_after");
        en = 1'b1;
    endtask

    task automatic test_back_to_back();
        run_frame(16'h1234, 16'hABCD, -1, -1, -1, "b2b_first");
        @(negedge clk);
        run_frame(16'hFEDC, 16'h0F0F, -1, -1, -1, "b2b_second");
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            run_frame(16'($urandom), 16'($urandom), int'($urandom_range(2, 240)), -1, -1, "b2b_rand");
        end
        check_quiet(5, "b2b");
    endtask

    task automatic test_reset_midframe();
        int bad;
        en = 1'b1;
        x = 16'($urandom);
        y = 16'($urandom);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midframe start bit: tx=%b required 0", tx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async reset: tx=%b busy=%b required tx=1 busy=0", tx, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < FRAME_CLKS + 20; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abandoned frame: %0d clocks with activity, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_snapshot_hold();
        test_overrun();
        test_enable();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
